// File: rtl/rr_lock_arbiter_if.sv
// Requester/downstream bundle for rr_lock_arbiter: request side in, grant side out.
interface rr_lock_arbiter_if #(
  parameter int WIDTH = 4
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] last;
  logic             ready;
  logic [WIDTH-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             busy;
  logic [WIDTH-1:0] base;

  modport master (
    output req, last, ready,
    input  grant, grant_idx, busy, base
  );

  modport slave (
    input  req, last, ready,
    output grant, grant_idx, busy, base
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the grant for a whole transaction and rotates
// the priority pointer past each released winner. Includes the fixed-priority core.

module fixed_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] grant
);
  logic [2*WIDTH-1:0] dreq;
  logic [2*WIDTH-1:0] dgnt;

  // Doubling the request vector lets the borrow from (req - base) wrap past WIDTH-1.
  always_comb begin
    dreq  = {req, req};
    dgnt  = dreq & ~(dreq - {{WIDTH{1'b0}}, base});
    grant = dgnt[WIDTH-1:0] | dgnt[2*WIDTH-1:WIDTH];
  end
endmodule

module rr_lock_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 4
) (
  input logic               clk,
  input logic               rst_n,
  rr_lock_arbiter_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] arb;
  logic             hold, fire, fire_last, at_limit, release_now;

  fixed_arbiter #(.WIDTH(WIDTH)) u_fixed (
    .req   (bus.req),
    .base  (base_q),
    .grant (arb)
  );

  function automatic logic [IW-1:0] onehot_idx(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) r = r | IW'(i);
    return r;
  endfunction

  always_comb begin
    hold        = |(grant_q & bus.req);
    fire        = hold & bus.ready;
    fire_last   = fire & |(grant_q & bus.last);
    at_limit    = (MAX_BEATS != 0) && fire && (cnt_q == LIMIT);
    release_now = fire_last | ~hold | at_limit;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = arb;
          idx_d   = onehot_idx(arb);
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          base_d  = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
          state_d = IDLE;
        end else if (fire) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      base_q  <= WIDTH'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.base      = base_q;
endmodule
